// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: state encoding and fixed timing constants shared by the reset sequencer.
package reset_sequencer_pkg;
  typedef enum logic [2:0] {HOLD, STAGE, RUN, SWHOLD, GATE} state_t;
  localparam int SYNC_STAGES = 2;
  localparam int GATE_CYCLES = 2;
endpackage

// File: rtl/reset_sequencer_rst_sync.sv
// rst_sync: board reset synchronizer, asynchronous assert and synchronous deassert.
module rst_sync
  import reset_sequencer_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  output logic sync_rst_n
);
  logic [SYNC_STAGES-1:0] sync;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], 1'b1};
  assign sync_rst_n = sync[SYNC_STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged per-domain reset release with software reset handshake.
// Define RESET_SEQUENCER_CLKEN_EN to add per-domain clk_en outputs and a clock-gating step before software resets.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   sw_rst_req,
  output logic                   sw_rst_ack,
  output logic [NUM_DOMAINS-1:0] out_rst_n,
`ifdef RESET_SEQUENCER_CLKEN_EN
  output logic [NUM_DOMAINS-1:0] clk_en,
`endif
  output logic                   all_released,
  output logic                   busy
);
  localparam int IDX_W = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DOMAINS - 1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [NUM_DOMAINS-1:0] out_nxt;
  logic rst_n, rel, pend, pend_set, pend_nxt, ack_nxt;

  rst_sync u_sync (.CLK(CLK), .RST_N(RST_N), .sync_rst_n(rst_n));

  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state      <= HOLD;
      cnt        <= '0;
      idx        <= '0;
      out_rst_n  <= '0;
      sw_rst_ack <= 1'b0;
      pend       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      out_rst_n  <= out_nxt;
      sw_rst_ack <= ack_nxt;
      pend       <= pend_nxt;
    end

  // Power-up HOLD compares against HOLD_CYCLES because the first counting edge follows synchronizer release.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    rel       = 1'b0;
    case (state)
      HOLD, SWHOLD: if (cnt == (state == HOLD ? CNT_W'(HOLD_CYCLES) : CNT_W'(HOLD_CYCLES - 1))) begin
        rel     = 1'b1;
        idx_nxt = '0;
      end
      STAGE: if (cnt == CNT_W'(STAGE_GAP - 1)) begin
        rel     = 1'b1;
        idx_nxt = idx + 1'b1;
      end
      RUN: begin
        cnt_nxt = '0;
`ifdef RESET_SEQUENCER_CLKEN_EN
        state_nxt = sw_rst_req ? GATE : RUN;
`else
        state_nxt = sw_rst_req ? SWHOLD : RUN;
`endif
      end
      GATE: if (cnt == CNT_W'(GATE_CYCLES - 1)) begin
        state_nxt = SWHOLD;
        cnt_nxt   = '0;
      end
      default: state_nxt = HOLD;
    endcase
    if (rel) begin
      cnt_nxt   = '0;
      state_nxt = idx_nxt == LAST ? RUN : STAGE;
    end
  end

  always_comb begin
    out_nxt = state_nxt == SWHOLD ? '0 : out_rst_n;
    if (rel) out_nxt[idx_nxt] = 1'b1;
    pend_set = pend | (state == SWHOLD & rel);
    ack_nxt  = state_nxt == RUN & state != RUN & pend_set;
    pend_nxt = pend_set & ~ack_nxt;
  end

`ifdef RESET_SEQUENCER_CLKEN_EN
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) clk_en <= '0;
    else clk_en <= (state_nxt == GATE || state_nxt == SWHOLD) ? '0 : out_rst_n;
`endif

  assign busy         = state != RUN;
  assign all_released = &out_rst_n;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized bench checking the sequencer against a release-schedule model.
module tb_reset_sequencer;
  localparam int N = 4, H = 16, G = 4;
`ifdef RESET_SEQUENCER_CLKEN_EN
  localparam int GD = 2;
`else
  localparam int GD = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, rst1_n = 1'b0, req = 1'b0;
  logic ack, all_rel, busy, ack1, all_rel1, busy1;
  logic [N-1:0] out, ce;
  logic [0:0] out1, ce1;
  int vectors = 0, errors = 0;
  int t = -1, start = 2, gate_t = 2, tdone = 2 + H + G * (N - 1);
  bit sw = 1'b0, in_rst = 1'b1;

  always #5 clk = ~clk;

  reset_sequencer u_dut (
    .CLK(clk), .RST_N(rst_n), .sw_rst_req(req), .sw_rst_ack(ack), .out_rst_n(out),
`ifdef RESET_SEQUENCER_CLKEN_EN
    .clk_en(ce),
`endif
    .all_released(all_rel), .busy(busy));

  reset_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGE_GAP(1)) u_min (
    .CLK(clk), .RST_N(rst1_n), .sw_rst_req(1'b0), .sw_rst_ack(ack1), .out_rst_n(out1),
`ifdef RESET_SEQUENCER_CLKEN_EN
    .clk_en(ce1),
`endif
    .all_released(all_rel1), .busy(busy1));

`ifndef RESET_SEQUENCER_CLKEN_EN
  assign ce  = '0;
  assign ce1 = '0;
`endif

  // Domain i is released H + G*i edges after the sequence start; a software request moves the start.
  function automatic logic [2*N+2:0] expect_vec();
    logic [N-1:0] o, c;
    for (int i = 0; i < N; i++) begin
      o[i] = !in_rst && (t >= start + H + G * i || (sw && t < start));
      c[i] = !in_rst && (t > start + H + G * i || (sw && t < gate_t));
    end
    if (GD == 0) c = '0;
    return {o, c, &o, in_rst || t < tdone, !in_rst && sw && t == tdone};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!in_rst) begin
      t++;
      if (t > tdone && req) begin
        sw     = 1'b1;
        gate_t = t;
        start  = t + GD;
        tdone  = start + H + G * (N - 1);
      end
    end
    #1;
  endtask

  task automatic assert_rst();
    rst_n  = 1'b0;
    in_rst = 1'b1;
    sw     = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n  = 1'b1;
    in_rst = 1'b0;
    t      = -1;
    start  = 2;
    gate_t = 2;
    tdone  = 2 + H + G * (N - 1);
  endtask

  task automatic test_reset();
    assert_rst();
    #1;
    vectors++;
    if ({out, ce, all_rel, busy, ack} !== expect_vec()) begin
      errors++;
      $display("FAIL reset_async t=%0d got %b want %b", t, {out, ce, all_rel, busy, ack}, expect_vec());
    end
    repeat (5) begin
      step();
      vectors++;
      if ({out, ce, all_rel, busy, ack} !== expect_vec()) begin
        errors++;
        $display("FAIL reset_hold t=%0d got %b want %b", t, {out, ce, all_rel, busy, ack}, expect_vec());
      end
    end
    release_rst();
  endtask

  task automatic test_power_up();
    repeat (36) begin
      step();
      vectors++;
      if ({out, ce, all_rel, busy, ack} !== expect_vec()) begin
        errors++;
        $display("FAIL power_up t=%0d got %b want %b", t, {out, ce, all_rel, busy, ack}, expect_vec());
      end
    end
  endtask

  task automatic test_sw_reset();
    bit got = 1'b0;
    while (t < 40) begin
      step();
      vectors++;
      if ({out, ce, all_rel, busy, ack} !== expect_vec()) begin
        errors++;
        $display("FAIL sw_pre t=%0d got %b want %b", t, {out, ce, all_rel, busy, ack}, expect_vec());
      end
    end
    req = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      step();
      vectors++;
      if ({out, ce, all_rel, busy, ack} !== expect_vec()) begin
        errors++;
        $display("FAIL sw_seq t=%0d got %b want %b", t, {out, ce, all_rel, busy, ack}, expect_vec());
      end
      if (ack) begin
        req = 1'b0;
        got = 1'b1;
      end
    end
    vectors++;
    if (!got) begin
      errors++;
      $display("FAIL sw_ack_timeout got no ack want ack within 100 cycles");
      req = 1'b0;
    end
    repeat (30) begin
      step();
      vectors++;
      if ({out, ce, all_rel, busy, ack} !== expect_vec()) begin
        errors++;
        $display("FAIL sw_post t=%0d got %b want %b", t, {out, ce, all_rel, busy, ack}, expect_vec());
      end
    end
  endtask

  task automatic test_early_req();
    bit got = 1'b0;
    assert_rst();
    req = 1'b1;
    repeat (3) step();
    release_rst();
    for (int n = 0; n < 200 && !got; n++) begin
      step();
      vectors++;
      if ({out, ce, all_rel, busy, ack} !== expect_vec()) begin
        errors++;
        $display("FAIL early_req t=%0d got %b want %b", t, {out, ce, all_rel, busy, ack}, expect_vec());
      end
      if (ack) begin
        req = 1'b0;
        got = 1'b1;
      end
    end
    vectors++;
    if (!got) begin
      errors++;
      $display("FAIL early_ack_timeout got no ack want ack within 200 cycles");
      req = 1'b0;
    end
    repeat (10) begin
      step();
      vectors++;
      if ({out, ce, all_rel, busy, ack} !== expect_vec()) begin
        errors++;
        $display("FAIL early_post t=%0d got %b want %b", t, {out, ce, all_rel, busy, ack}, expect_vec());
      end
    end
  endtask

  task automatic test_abort();
    while (t < 24) step();
    assert_rst();
    #1;
    vectors++;
    if ({out, ce, all_rel, busy, ack} !== expect_vec()) begin
      errors++;
      $display("FAIL abort_async t=%0d got %b want %b", t, {out, ce, all_rel, busy, ack}, expect_vec());
    end
    repeat (3) step();
    release_rst();
    repeat (40) begin
      step();
      vectors++;
      if ({out, ce, all_rel, busy, ack} !== expect_vec()) begin
        errors++;
        $display("FAIL abort_restart t=%0d got %b want %b", t, {out, ce, all_rel, busy, ack}, expect_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      bit done = 1'b0;
      int abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : -1;
      repeat ($urandom_range(0, 8)) step();
      req = 1'b1;
      for (int n = 0; n < 300 && !done; n++) begin
        step();
        vectors++;
        if ({out, ce, all_rel, busy, ack} !== expect_vec()) begin
          errors++;
          $display("FAIL random it=%0d t=%0d got %b want %b", it, t, {out, ce, all_rel, busy, ack}, expect_vec());
        end
        if (ack) begin
          req  = 1'b0;
          done = 1'b1;
        end else if (n == abort_at) begin
          assert_rst();
          req = 1'($urandom_range(0, 1));
          #1;
          vectors++;
          if ({out, ce, all_rel, busy, ack} !== expect_vec()) begin
            errors++;
            $display("FAIL random_abort it=%0d got %b want %b", it, {out, ce, all_rel, busy, ack}, expect_vec());
          end
          repeat ($urandom_range(1, 4)) step();
          release_rst();
        end else if (!req && !in_rst && t > tdone) done = 1'b1;
      end
      if (!done) begin
        errors++;
        $display("FAIL random_timeout it=%0d got busy want sequence done within 300 cycles", it);
        req = 1'b0;
      end
    end
  endtask

  task automatic test_corner();
    @(negedge clk);
    rst1_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({out1, ce1, all_rel1, busy1, ack1} !== {k >= 3, GD != 0 && k >= 4, k >= 3, k < 3, 1'b0}) begin
        errors++;
        $display("FAIL corner k=%0d got %b want %b", k, {out1, ce1, all_rel1, busy1, ack1},
                 {k >= 3, GD != 0 && k >= 4, k >= 3, k < 3, 1'b0});
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_power_up();
    test_sw_reset();
    test_early_req();
    assert_rst();
    repeat (2) step();
    release_rst();
    test_abort();
    test_random();
    test_corner();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Reset/clock-domain controller. Takes the board-level clock and reset and produces NUM_DOMAINS staged active-low resets for downstream BSV-generated modules.
- Holds all domains in reset for a minimum time, then releases them in fixed order (domain 0 first) with a programmable gap between releases.
- Accepts a software reset request over a req/ack handshake; this re-asserts every domain and re-runs the release sequence.
- Sits between the top-level clock/reset entry and the portal/user logic.

Parameters:
- NUM_DOMAINS, 4, number of staged reset outputs (1..16).
- HOLD_CYCLES, 16, cycles all domains stay asserted before the first release (>=1).
- STAGE_GAP, 4, cycles between consecutive domain releases (>=1).
- CNT_W, 8, counter width; must hold max(HOLD_CYCLES, STAGE_GAP).

Ports:
- CLK  input  1  sole clock.
- RST_N  input  1  reset, asynchronous, active-low.
- sw_rst_req  input  1  software reset request, level; held until ack.
- sw_rst_ack  output  1  one-cycle pulse when a software-initiated sequence completes.
- out_rst_n  output  NUM_DOMAINS  staged active-low resets; bit i = domain i.
- all_released  output  1  high when every out_rst_n bit is 1.
- busy  output  1  high in any state other than RUN.

Behaviour:
- RST_N low: asynchronously forces out_rst_n=0, all_released=0, sw_rst_ack=0, busy=1, FSM=HOLD, counters=0.
- RST_N deassertion passes through a 2-flop synchronizer. The internal reset releases on the 2nd CLK rising edge with RST_N high.
- FSM states: HOLD, STAGE, RUN, SWHOLD.
- HOLD: counts HOLD_CYCLES cycles, then goes to STAGE with idx=0.
- STAGE: sets out_rst_n[idx]=1 on entry, waits STAGE_GAP cycles, then idx++.
- STAGE exit: after releasing idx=NUM_DOMAINS-1, goes to RUN in the same cycle the last bit rises. No gap wait after the last domain.
- RUN: busy=0, all_released=1. sw_rst_req=1 sampled -> SWHOLD.
- SWHOLD: on entry, out_rst_n=0 for all bits synchronously (next edge). Counts HOLD_CYCLES, then goes to STAGE with idx=0 and a pending-ack flag set.
- Ack: on entry to RUN with the pending-ack flag set, sw_rst_ack pulses for exactly 1 cycle and the flag clears.
- sw_rst_req is ignored outside RUN. A request held through power-up sequencing is honoured on the first RUN cycle.
- If req is still high on the cycle after ack, a new sequence starts. Requester must drop req on ack.
- Release timing with defaults, t=0 being the first edge with RST_N high:
  - out_rst_n[i] rises at edge 2+16+4*i, i.e. 18, 22, 26, 30.
  - all_released rises at edge 30.
- NUM_DOMAINS=1: single release, no gap; all_released coincides with out_rst_n[0].
- RST_N asserted mid-sequence (any state) aborts immediately (asynchronously) and clears the pending-ack flag. No ack is issued for the aborted request.
- Outputs are registered; out_rst_n only ever changes 0->1 in STAGE, or goes to 0 on SWHOLD entry or RST_N.

Optional Feature:
- Macro: RESET_SEQUENCER_CLKEN_EN.
- Defined:
  - Adds output clk_en [NUM_DOMAINS].
  - clk_en[i] rises 1 cycle after out_rst_n[i] rises.
  - On a software request, a GATE state is inserted between RUN and SWHOLD. GATE drops all clk_en, waits 2 cycles, then enters SWHOLD.
  - RST_N low forces clk_en=0.
- Undefined: no clk_en port, no GATE state; RUN goes directly to SWHOLD.

Decomposition:
- Package reset_sequencer_pkg holds:
  - state enum (HOLD, STAGE, RUN, SWHOLD, GATE);
  - SYNC_STAGES=2;
  - GATE_CYCLES=2.
- Sub-module rst_sync: 2-flop synchronizer, asynchronous assert, synchronous deassert. CLK and RST_N in, synced reset out.

Test Plan:
- Power-up: RST_N low 5 cycles, then high.
  - out_rst_n 0000 -> 0001@18, 0011@22, 0111@26, 1111@30.
  - all_released@30, busy falls @30.
- SW reset: at edge 40 raise sw_rst_req.
  - out_rst_n=0000 @41.
  - Re-release at 41+16=57, 61, 65, 69.
  - sw_rst_ack single pulse @69; drop req @70.
  - No second sequence.
- Early request: hold sw_rst_req=1 from t=0.
  - Power-up completes @30 with no ack.
  - SWHOLD entered @31; ack after the second sequence.
- Mid-sequence abort: RST_N low at edge 24 during STAGE.
  - out_rst_n=0000 immediately (asynchronous, before next edge).
  - After release, full sequence restarts from HOLD; no stray ack.
- Parameter corner: NUM_DOMAINS=1, HOLD_CYCLES=1, STAGE_GAP=1.
  - out_rst_n[0] rises @3, all_released @3.
- Feature build with RESET_SEQUENCER_CLKEN_EN:
  - clk_en[0] rises @19, clk_en[3] @31.
  - SW request @40: clk_en=0 @41, resets asserted @43.
